mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side signal bundle for mem_port_arbiter.
// slave = arbiter view, master = requester/memory (environment) view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned BLOCK_W = 128
);
  logic               I_READ;
  logic [ADDR_W-1:0]  I_ADDRESS;
  logic [BLOCK_W-1:0] I_READDATA;
  logic               I_BUSYWAIT;

  logic               D_READ;
  logic               D_WRITE;
  logic [ADDR_W-1:0]  D_ADDRESS;
  logic [BLOCK_W-1:0] D_WRITEDATA;
  logic [BLOCK_W-1:0] D_READDATA;
  logic               D_BUSYWAIT;

  logic               MEM_READ;
  logic               MEM_WRITE;
  logic [ADDR_W-1:0]  MEM_ADDRESS;
  logic [BLOCK_W-1:0] MEM_WRITEDATA;
  logic [BLOCK_W-1:0] MEM_READDATA;
  logic               MEM_BUSYWAIT;

  modport slave (
    input  I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
           MEM_READDATA, MEM_BUSYWAIT,
    output I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
           MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
           MEM_READDATA, MEM_BUSYWAIT,
    input  I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
           MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the I-cache and D-cache block ports onto one main-memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; default is D-first.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned BLOCK_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  state_t             state_q;
  logic               first_q;
  logic               done_i_q;
  logic               done_d_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [BLOCK_W-1:0] mem_wdata_q;
  logic [BLOCK_W-1:0] i_rdata_q;
  logic [BLOCK_W-1:0] d_rdata_q;

  logic i_req;
  logic d_req;
  logic grant_d;

  assign i_req = bus.I_READ;
  assign d_req = bus.D_READ | bus.D_WRITE;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // ptr_d_q high means D wins the next contention.
  logic ptr_d_q;
  assign grant_d = d_req & (~i_req | ptr_d_q);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      first_q     <= 1'b0;
      done_i_q    <= 1'b0;
      done_d_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_d_q     <= 1'b0;
`endif
    end else begin
      done_i_q <= 1'b0;
      done_d_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q     <= SERVE_D;
            first_q     <= 1'b1;
            mem_addr_q  <= bus.D_ADDRESS;
            mem_read_q  <= bus.D_READ;
            mem_write_q <= bus.D_WRITE;
            if (bus.D_WRITE) mem_wdata_q <= bus.D_WRITEDATA;
          end else if (i_req) begin
            state_q     <= SERVE_I;
            first_q     <= 1'b1;
            mem_addr_q  <= bus.I_ADDRESS;
            mem_read_q  <= 1'b1;
            mem_write_q <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          // Memory busy is only meaningful once it has seen the strobe for a cycle.
          if (first_q) begin
            first_q <= 1'b0;
          end else if (!bus.MEM_BUSYWAIT) begin
            state_q     <= RELEASE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (state_q == SERVE_I) begin
              i_rdata_q <= bus.MEM_READDATA;
              done_i_q  <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
              ptr_d_q   <= 1'b1;
`endif
            end else begin
              if (mem_read_q) d_rdata_q <= bus.MEM_READDATA;
              done_d_q  <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
              ptr_d_q   <= 1'b0;
`endif
            end
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.MEM_READ      = mem_read_q;
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDRESS   = mem_addr_q;
  assign bus.MEM_WRITEDATA = mem_wdata_q;
  assign bus.I_READDATA    = i_rdata_q;
  assign bus.D_READDATA    = d_rdata_q;
  assign bus.I_BUSYWAIT    = i_req & ~done_i_q;
  assign bus.D_BUSYWAIT    = d_req & ~done_d_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, contention and reset
// sequences, then random traffic against a transaction-level memory model.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W  = 28;
  localparam int unsigned BLOCK_W = 128;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int unsigned passed = 0;
  int unsigned total  = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();
  mem_port_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;

  // Memory responder: busy for mem_lat cycles after the strobe first appears.
  int unsigned        mem_lat  = 0;
  int unsigned        mem_cnt  = 0;
  bit                 rand_mode = 1'b0;
  logic [BLOCK_W-1:0] dir_rdata = '0;
  logic [BLOCK_W-1:0] phys [16];
  bit                 phys_vld [16];
  logic               strobe;
  logic [3:0]         pidx;

  function automatic logic [BLOCK_W-1:0] pat(input logic [3:0] a);
    logic [31:0] w;
    w = (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    return {4{w}};
  endfunction

  assign strobe = bus.MEM_READ | bus.MEM_WRITE;
  assign pidx   = bus.MEM_ADDRESS[3:0];
  assign bus.MEM_BUSYWAIT = strobe && (mem_cnt < mem_lat);
  assign bus.MEM_READDATA = rand_mode ? (phys_vld[pidx] ? phys[pidx] : pat(pidx)) : dir_rdata;

  always @(posedge clock) begin
    if (strobe) mem_cnt <= mem_cnt + 1;
    else        mem_cnt <= 0;
    if (rand_mode && bus.MEM_WRITE) begin
      phys[pidx]     <= bus.MEM_WRITEDATA;
      phys_vld[pidx] <= 1'b1;
    end
  end

  logic [BLOCK_W-1:0] model_mem [16];
  bit ptr_d = 1'b0;  // model: D wins next contention (round-robin build only)

  task automatic check(input string name, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic bit winner_d(input bit i_pend, input bit d_pend);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return d_pend && (!i_pend || ptr_d);
`else
    return d_pend;
`endif
  endfunction

  task automatic clear_inputs();
    bus.I_READ = 1'b0; bus.I_ADDRESS = '0;
    bus.D_READ = 1'b0; bus.D_WRITE = 1'b0; bus.D_ADDRESS = '0; bus.D_WRITEDATA = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    clear_inputs();
    reset = 1'b1;
    #2 reset = 1'b0;
    ptr_d = 1'b0;
  endtask

  typedef struct {
    bit                 is_d;
    bit                 wr;
    logic [ADDR_W-1:0]  addr;
    logic [BLOCK_W-1:0] wdata;
    logic [BLOCK_W-1:0] mem_data;
    int unsigned        lat;
    logic [BLOCK_W-1:0] exp_rdata;
    int unsigned        exp_cycles;
  } vec_t;

  function automatic vec_t mk(input bit is_d, input bit wr, input logic [ADDR_W-1:0] addr,
                              input logic [BLOCK_W-1:0] wd, input logic [BLOCK_W-1:0] md,
                              input int unsigned lat, input logic [BLOCK_W-1:0] er,
                              input int unsigned ec);
    vec_t v;
    v.is_d = is_d; v.wr = wr; v.addr = addr; v.wdata = wd; v.mem_data = md;
    v.lat = lat; v.exp_rdata = er; v.exp_cycles = ec;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int unsigned idx);
    int unsigned cycles = 0;
    bit done = 1'b0;
    bit bad_bus = 1'b0;
    @(negedge clock);
    mem_lat = v.lat; dir_rdata = v.mem_data;
    if (v.is_d) begin
      bus.D_READ = !v.wr; bus.D_WRITE = v.wr; bus.D_ADDRESS = v.addr; bus.D_WRITEDATA = v.wdata;
    end else begin
      bus.I_READ = 1'b1; bus.I_ADDRESS = v.addr;
    end
    #1 check($sformatf("vec%0d busy_rise", idx), v.is_d ? bus.D_BUSYWAIT : bus.I_BUSYWAIT, 1);
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clock);
      if (strobe) begin
        cycles++;
        if (bus.MEM_ADDRESS !== v.addr || bus.MEM_WRITE !== (v.is_d & v.wr) ||
            bus.MEM_READ !== !(v.is_d & v.wr) || (v.wr && bus.MEM_WRITEDATA !== v.wdata))
          bad_bus = 1'b1;
      end
      if (!(v.is_d ? bus.D_BUSYWAIT : bus.I_BUSYWAIT)) done = 1'b1;
    end
    check($sformatf("vec%0d done", idx), done, 1);
    check($sformatf("vec%0d strobe_cycles", idx), cycles, v.exp_cycles);
    check($sformatf("vec%0d bus_fields", idx), bad_bus, 0);
    check($sformatf("vec%0d rdata", idx), v.is_d ? bus.D_READDATA : bus.I_READDATA, v.exp_rdata);
    ptr_d = !v.is_d;
    clear_inputs();
  endtask

  task automatic contend(input string tag);
    logic [ADDR_W-1:0] ia, da;
    bit grants [$];
    bit prev_st = 1'b0, i_pend = 1'b1, d_pend = 1'b1, loser_busy_ok = 1'b1;
    bit exp_d_first;
    int first_done_c = -100, second_grant_c = -1;
    int g0, g1;
    exp_d_first = winner_d(1'b1, 1'b1);
    ia = ADDR_W'(28'h0000100 + $urandom_range(0, 255));
    da = ADDR_W'(28'h0000200 + $urandom_range(0, 255));
    @(negedge clock);
    mem_lat = 2; dir_rdata = {4{$urandom}};
    bus.I_READ = 1'b1; bus.I_ADDRESS = ia;
    bus.D_READ = 1'b1; bus.D_ADDRESS = da;
    for (int c = 0; c < 80 && (i_pend || d_pend); c++) begin
      @(negedge clock);
      if (strobe && !prev_st) begin
        grants.push_back(bus.MEM_ADDRESS == da);
        if (grants.size() == 2) second_grant_c = c;
      end
      prev_st = strobe;
      if (i_pend && d_pend && !(exp_d_first ? bus.I_BUSYWAIT : bus.D_BUSYWAIT)) loser_busy_ok = 1'b0;
      if (i_pend && !bus.I_BUSYWAIT) begin
        i_pend = 1'b0; bus.I_READ = 1'b0; ptr_d = 1'b1;
        if (d_pend) first_done_c = c;
      end
      if (d_pend && !bus.D_BUSYWAIT) begin
        d_pend = 1'b0; bus.D_READ = 1'b0; ptr_d = 1'b0;
        if (i_pend) first_done_c = c;
      end
    end
    g0 = (grants.size() > 0) ? int'(grants[0]) : 2;
    g1 = (grants.size() > 1) ? int'(grants[1]) : 2;
    check({tag, " grant_count"}, grants.size(), 2);
    check({tag, " first_is_d"}, g0, exp_d_first);
    check({tag, " second_is_d"}, g1, !exp_d_first);
    check({tag, " loser_busy"}, loser_busy_ok, 1);
    check({tag, " regrant_gap"}, second_grant_c - first_done_c, 2);
    check({tag, " both_done"}, i_pend | d_pend, 0);
    clear_inputs();
  endtask

  task automatic run_random(input int unsigned n);
    bit prev_st = 1'b0, has_owner = 1'b0, own_d = 1'b0, i_req_e = 1'b0, d_req_e = 1'b0, d_w = 1'b0;
    logic [ADDR_W-1:0]  i_a = '0, d_a = '0;
    logic [BLOCK_W-1:0] d_wd = '0, d_last = '0;
    int unsigned i_age = 0, d_age = 0;
    for (int unsigned k = 0; k < 16; k++) model_mem[k] = pat(4'(k));
    pulse_reset();
    rand_mode = 1'b1;
    for (int unsigned cyc = 0; cyc < n; cyc++) begin
      @(negedge clock);
      if (strobe && !prev_st) begin
        own_d = winner_d(i_req_e, d_req_e);
        has_owner = 1'b1;
        check("rand grant", {bus.MEM_ADDRESS, bus.MEM_READ, bus.MEM_WRITE},
              own_d ? {d_a, !d_w, d_w} : {i_a, 1'b1, 1'b0});
        if (own_d && d_w) check("rand wdata", bus.MEM_WRITEDATA, d_wd);
      end
      prev_st = strobe;
      if (!strobe) mem_lat = $urandom_range(0, 3);

      if (bus.I_READ) i_age++;
      if (bus.I_READ && !bus.I_BUSYWAIT) begin
        check("rand i owner", has_owner && !own_d, 1);
        check("rand i data", bus.I_READDATA, model_mem[i_a[3:0]]);
        has_owner = 1'b0; ptr_d = 1'b1; bus.I_READ = 1'b0; i_age = 0;
      end else if (i_age > 100) begin
        check("rand i timeout", i_age, 0);
        bus.I_READ = 1'b0; i_age = 0;
      end else if (!bus.I_READ && $urandom_range(0, 3) == 0) begin
        i_a = ADDR_W'($urandom);
        bus.I_ADDRESS = i_a; bus.I_READ = 1'b1;
      end

      if (bus.D_READ || bus.D_WRITE) d_age++;
      if ((bus.D_READ || bus.D_WRITE) && !bus.D_BUSYWAIT) begin
        check("rand d owner", has_owner && own_d, 1);
        if (d_w) begin
          model_mem[d_a[3:0]] = d_wd;
          check("rand d hold", bus.D_READDATA, d_last);
        end else begin
          d_last = model_mem[d_a[3:0]];
          check("rand d data", bus.D_READDATA, d_last);
        end
        has_owner = 1'b0; ptr_d = 1'b0; bus.D_READ = 1'b0; bus.D_WRITE = 1'b0; d_age = 0;
      end else if (d_age > 100) begin
        check("rand d timeout", d_age, 0);
        bus.D_READ = 1'b0; bus.D_WRITE = 1'b0; d_age = 0;
      end else if (!(bus.D_READ || bus.D_WRITE) && $urandom_range(0, 3) == 0) begin
        d_a  = ADDR_W'($urandom);
        d_w  = 1'($urandom_range(0, 1));
        d_wd = {$urandom, $urandom, $urandom, $urandom};
        bus.D_ADDRESS = d_a; bus.D_WRITEDATA = d_wd;
        bus.D_READ = !d_w; bus.D_WRITE = d_w;
      end
      i_req_e = bus.I_READ;
      d_req_e = bus.D_READ | bus.D_WRITE;
    end
    rand_mode = 1'b0;
    clear_inputs();
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = mk(0, 0, 28'h0000012, '0, {16{8'hA5}}, 4, {16{8'hA5}}, 5);
    vecs[1] = mk(1, 1, 28'h0000040, 128'h1234, '0, 2, '0, 3);
    vecs[2] = mk(1, 0, 28'hFFFFFFF, '0, {4{32'hDEADBEEF}}, 0, {4{32'hDEADBEEF}}, 2);
    vecs[3] = mk(0, 0, 28'h0000000, '0, {2{64'h0123456789ABCDEF}}, 1, {2{64'h0123456789ABCDEF}}, 2);
    vecs[4] = mk(1, 1, 28'h5555555, '1, '0, 3, {4{32'hDEADBEEF}}, 4);
    vecs[5] = mk(0, 0, 28'hAAAAAAA, '0, '0, 0, '0, 2);

    clear_inputs();
    #1 reset = 1'b1;
    #1;
    check("rst mem_read", bus.MEM_READ, 0);
    check("rst mem_write", bus.MEM_WRITE, 0);
    check("rst mem_address", bus.MEM_ADDRESS, 0);
    check("rst mem_writedata", bus.MEM_WRITEDATA, 0);
    check("rst i_readdata", bus.I_READDATA, 0);
    check("rst d_readdata", bus.D_READDATA, 0);
    check("rst i_busy_idle", bus.I_BUSYWAIT, 0);
    bus.I_READ = 1'b1;
    #1 check("rst i_busy_req", bus.I_BUSYWAIT, 1);
    bus.I_READ = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    @(negedge clock);
    check("idle keeps address", bus.MEM_ADDRESS, 28'hAAAAAAA);
    check("idle keeps writedata", bus.MEM_WRITEDATA, '1);
    check("idle strobes low", strobe, 0);

    contend("contend0");
    pulse_reset();
    for (int r = 0; r < 4; r++) contend($sformatf("rr%0d", r));

    // Reset in the second SERVE_D cycle; memory would complete at that edge.
    pulse_reset();
    @(negedge clock);
    mem_lat = 0; dir_rdata = {4{32'hCAFEF00D}};
    bus.D_READ = 1'b1; bus.D_ADDRESS = 28'h0000ABC;
    @(negedge clock);
    check("abort serve1 read", bus.MEM_READ, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort strobe low", strobe, 0);
    check("abort address clear", bus.MEM_ADDRESS, 0);
    check("abort no capture", bus.D_READDATA, 0);
    check("abort busy held", bus.D_BUSYWAIT, 1);
    #1 reset = 1'b0;
    ptr_d = 1'b0;
    @(negedge clock);
    check("abort regrant", {bus.MEM_ADDRESS, bus.MEM_READ}, {28'h0000ABC, 1'b1});
    for (int c = 0; c < 20 && bus.D_BUSYWAIT; c++) @(negedge clock);
    check("abort retry data", bus.D_READDATA, {4{32'hCAFEF00D}});
    clear_inputs();

    run_random(3000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
